// File: rtl/load_store_responder_pkg.sv
// Shared types for the load/store responder: command encodings, access size,
// per-op control struct and FSM state codes.
package load_store_responder_pkg;

  typedef enum logic [1:0] {
    MEM_LOAD  = 2'd0,
    MEM_STORE = 2'd1,
    MEM_FENCE = 2'd2
  } mem_unit_command_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } access_size_t;

  typedef struct packed {
    access_size_t size;
    logic         is_unsigned;
    logic         is_fp;
  } load_store_unit_command_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FLUSH     = 3'd1;
  localparam logic [2:0] ST_TRANSLATE = 3'd2;
  localparam logic [2:0] ST_ACCESS    = 3'd3;
  localparam logic [2:0] ST_WAIT_READ = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // D accesses are two 32-bit beats; everything else is a single beat.
  function automatic logic is_last_beat(access_size_t size, logic beat);
    return (size != SIZE_D) || beat;
  endfunction

endpackage

// File: rtl/load_store_responder_aligner.sv
// Combinational lane steering: store byte mask and data shift, load extract,
// sign/zero extension and NaN-boxing of FP words.
module load_store_responder_aligner
  import load_store_responder_pkg::*;
(
  input  load_store_unit_command_t lsc,
  input  logic [1:0]               lane,
  input  logic                     beat,
  input  logic [31:0]              int_data,
  input  logic [63:0]              fp_data,
  input  logic [31:0]              rd_word,
  input  logic [31:0]              lo_word,
  output logic [3:0]               byte_en,
  output logic [31:0]              wr_word,
  output logic [63:0]              ld_value
);

  logic [4:0]  shamt;
  logic [31:0] src;
  logic [31:0] rd_sh;

  assign shamt = {lane, 3'b000};

  always_comb begin
    byte_en = 4'b1111;
    src     = int_data;
    wr_word = int_data;
    rd_sh   = rd_word >> shamt;
    ld_value = '0;

    if (lsc.size == SIZE_D)
      src = beat ? fp_data[63:32] : fp_data[31:0];
    else if (lsc.size == SIZE_W && lsc.is_fp)
      src = fp_data[31:0];

    // Only sub-word accesses are lane-shifted; W/D are always word aligned.
    case (lsc.size)
      SIZE_B: begin
        byte_en  = 4'b0001 << lane;
        wr_word  = src << shamt;
        ld_value = lsc.is_unsigned ? {56'd0, rd_sh[7:0]}
                                   : {{56{rd_sh[7]}}, rd_sh[7:0]};
      end
      SIZE_H: begin
        byte_en  = 4'b0011 << lane;
        wr_word  = src << shamt;
        ld_value = lsc.is_unsigned ? {48'd0, rd_sh[15:0]}
                                   : {{48{rd_sh[15]}}, rd_sh[15:0]};
      end
      SIZE_W: begin
        wr_word  = src;
        ld_value = lsc.is_fp ? {32'hFFFF_FFFF, rd_word}
                             : {{32{rd_word[31]}}, rd_word};
      end
      default: begin
        wr_word  = src;
        ld_value = {rd_word, lo_word};
      end
    endcase
  end

endmodule

// File: rtl/load_store_responder.sv
// Load/store unit responder: computes VA, translates via the TLB port, runs
// one or two 32-bit bus beats and returns a one-cycle done with results.
module load_store_responder
  import load_store_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     invalidateTlb,
  input  mem_unit_command_t        command,
  input  load_store_unit_command_t loadStoreUnitCommand,
  input  logic [31:0]              imm,
  input  logic [31:0]              srcIntRegValue1,
  input  logic [31:0]              srcIntRegValue2,
  input  logic [63:0]              srcFpRegValue2,
  output logic                     done,
  output logic                     loadPagefault,
  output logic                     storePagefault,
  output logic [31:0]              resultAddr,
  output logic [63:0]              resultValue,
  output logic                     tlbReq,
  output logic [31:0]              tlbVirtAddr,
  input  logic                     tlbDone,
  input  logic                     tlbFault,
  input  logic [31:0]              tlbPhysAddr,
  output logic                     tlbFlush,
  input  logic                     tlbFlushDone,
  output logic                     memReq,
  output logic                     memWrite,
  output logic [31:0]              memAddr,
  output logic [3:0]               memByteEnable,
  output logic [31:0]              memWriteValue,
  input  logic                     memGrant,
  input  logic                     memReadValid,
  input  logic [31:0]              memReadValue
);

  logic [2:0]               state;
  logic [31:0]              va;
  logic [31:0]              pa;
  mem_unit_command_t        cmd_q;
  load_store_unit_command_t lsc_q;
  logic                     beat;
  logic [31:0]              lo_word;

  logic [31:0] va_next;
  logic        is_store;
  logic        last;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic [63:0] ld_value;

  assign va_next  = srcIntRegValue1 + imm;
  assign is_store = (cmd_q == MEM_STORE);
  assign last     = is_last_beat(lsc_q.size, beat);

  // Requests decode straight from state so they drop on the edge that sees the ack.
  assign done          = (state == ST_DONE);
  assign tlbReq        = (state == ST_TRANSLATE);
  assign tlbVirtAddr   = va;
  assign tlbFlush      = (state == ST_FLUSH);
  assign memReq        = (state == ST_ACCESS);
  assign memWrite      = memReq & is_store;
  assign memAddr       = {pa[31:2] + {29'd0, beat}, 2'b00};
  assign memByteEnable = memWrite ? byte_en : 4'b0000;
  assign memWriteValue = memWrite ? wr_word : 32'd0;

  load_store_responder_aligner u_aligner (
    .lsc      (lsc_q),
    .lane     (pa[1:0]),
    .beat     (beat),
    .int_data (srcIntRegValue2),
    .fp_data  (srcFpRegValue2),
    .rd_word  (memReadValue),
    .lo_word  (lo_word),
    .byte_en  (byte_en),
    .wr_word  (wr_word),
    .ld_value (ld_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      va             <= '0;
      pa             <= '0;
      cmd_q          <= MEM_LOAD;
      lsc_q          <= '0;
      beat           <= 1'b0;
      lo_word        <= '0;
      resultAddr     <= '0;
      resultValue    <= '0;
      loadPagefault  <= 1'b0;
      storePagefault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            // Result registers are primed at op start; later states only
            // overwrite what the op actually produces.
            va             <= va_next;
            cmd_q          <= command;
            lsc_q          <= loadStoreUnitCommand;
            beat           <= 1'b0;
            resultAddr     <= va_next;
            resultValue    <= '0;
            loadPagefault  <= 1'b0;
            storePagefault <= 1'b0;
            if (invalidateTlb)
              state <= ST_FLUSH;
            else if (command == MEM_FENCE)
              state <= ST_DONE;
            else
              state <= ST_TRANSLATE;
          end
        end
        ST_FLUSH: begin
          if (tlbFlushDone) state <= ST_DONE;
        end
        ST_TRANSLATE: begin
          if (tlbDone) begin
            if (tlbFault) begin
              loadPagefault  <= (cmd_q == MEM_LOAD);
              storePagefault <= is_store;
              state          <= ST_DONE;
            end else begin
              pa    <= tlbPhysAddr;
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (memGrant) begin
            if (is_store) begin
              if (last) state <= ST_DONE;
              else      beat  <= 1'b1;
            end else if (memReadValid) begin
              if (last) begin
                resultValue <= ld_value;
                state       <= ST_DONE;
              end else begin
                lo_word <= memReadValue;
                beat    <= 1'b1;
              end
            end else begin
              state <= ST_WAIT_READ;
            end
          end
        end
        ST_WAIT_READ: begin
          if (memReadValid) begin
            if (last) begin
              resultValue <= ld_value;
              state       <= ST_DONE;
            end else begin
              lo_word <= memReadValue;
              beat    <= 1'b1;
              state   <= ST_ACCESS;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_responder.sv
// Directed bench for load_store_responder with TLB/bus responder models and
// a scoreboard of expected results popped on each done pulse.
module tb_load_store_responder;
  import load_store_responder_pkg::*;

  logic clk, rst, enable, invalidateTlb;
  mem_unit_command_t        command;
  load_store_unit_command_t loadStoreUnitCommand;
  logic [31:0] imm, srcIntRegValue1, srcIntRegValue2;
  logic [63:0] srcFpRegValue2;
  logic done, loadPagefault, storePagefault;
  logic [31:0] resultAddr;
  logic [63:0] resultValue;
  logic tlbReq, tlbDone, tlbFault, tlbFlush, tlbFlushDone;
  logic [31:0] tlbVirtAddr, tlbPhysAddr;
  logic memReq, memWrite, memGrant, memReadValid;
  logic [31:0] memAddr, memWriteValue, memReadValue;
  logic [3:0]  memByteEnable;

  load_store_responder dut (
    .clk(clk), .rst(rst), .enable(enable), .invalidateTlb(invalidateTlb),
    .command(command), .loadStoreUnitCommand(loadStoreUnitCommand),
    .imm(imm), .srcIntRegValue1(srcIntRegValue1), .srcIntRegValue2(srcIntRegValue2),
    .srcFpRegValue2(srcFpRegValue2), .done(done), .loadPagefault(loadPagefault),
    .storePagefault(storePagefault), .resultAddr(resultAddr), .resultValue(resultValue),
    .tlbReq(tlbReq), .tlbVirtAddr(tlbVirtAddr), .tlbDone(tlbDone), .tlbFault(tlbFault),
    .tlbPhysAddr(tlbPhysAddr), .tlbFlush(tlbFlush), .tlbFlushDone(tlbFlushDone),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
    .memByteEnable(memByteEnable), .memWriteValue(memWriteValue),
    .memGrant(memGrant), .memReadValid(memReadValid), .memReadValue(memReadValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder models: zero-wait TLB, bus read data either next cycle or same cycle.
  logic [31:0] tlb_off;
  logic        tlb_fault_cfg, rd_same, mem_stall;
  logic [31:0] mem [0:16383];
  logic        rd_pend;
  logic [31:0] rd_q;
  int          flush_cnt, flush_cycles, memreq_cycles;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] addr; logic [63:0] value; logic lpf; logic spf; } exp_t;
  wr_t  wq[$];
  exp_t sb[$];

  assign tlbDone      = tlbReq;
  assign tlbFault     = tlbReq & tlb_fault_cfg;
  assign tlbPhysAddr  = tlbVirtAddr + tlb_off;
  assign tlbFlushDone = tlbFlush & (flush_cnt == 2);
  assign memGrant     = memReq & ~mem_stall;
  assign memReadValid = rd_same ? (memGrant & ~memWrite) : rd_pend;
  assign memReadValue = rd_same ? mem[memAddr[15:2]] : rd_q;

  initial begin
    rd_pend = 1'b0; rd_q = '0;
    flush_cnt = 0; flush_cycles = 0; memreq_cycles = 0;
  end

  always @(posedge clk) begin
    rd_pend <= memGrant & ~memWrite & ~rd_same;
    rd_q    <= mem[memAddr[15:2]];
    if (memGrant & memWrite) wq.push_back('{memAddr, memByteEnable, memWriteValue});
    if (memReq) memreq_cycles <= memreq_cycles + 1;
    if (tlbFlush) begin
      flush_cnt    <= flush_cnt + 1;
      flush_cycles <= flush_cycles + 1;
    end else flush_cnt <= 0;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input mem_unit_command_t c, input access_size_t sz,
                       input logic uns, input logic fp, input logic inv,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] d2, input logic [63:0] f2,
                       input logic [63:0] exp_val, input logic elpf, input logic espf,
                       input int exp_lat);
    int lat;
    logic got;
    exp_t e;
    sb.push_back('{base + off, exp_val, elpf, espf});
    @(negedge clk);
    command = c;
    loadStoreUnitCommand = '{sz, uns, fp};
    invalidateTlb = inv;
    srcIntRegValue1 = base; imm = off;
    srcIntRegValue2 = d2; srcFpRegValue2 = f2;
    enable = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    if (got) begin
      check({tag, " resultAddr"}, {32'd0, resultAddr}, {32'd0, e.addr});
      check({tag, " resultValue"}, resultValue, e.value);
      check({tag, " loadPagefault"}, {63'd0, loadPagefault}, {63'd0, e.lpf});
      check({tag, " storePagefault"}, {63'd0, storePagefault}, {63'd0, e.spf});
    end
    enable = 1'b0;
    invalidateTlb = 1'b0;
    @(negedge clk);
    check({tag, " done one pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] d);
    wr_t w;
    check({tag, " write seen"}, 64'(wq.size() > 0), 64'd1);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      check({tag, " memAddr"}, {32'd0, w.addr}, {32'd0, a});
      check({tag, " memByteEnable"}, {60'd0, w.be}, {60'd0, be});
      check({tag, " memWriteValue"}, {32'd0, w.data}, {32'd0, d});
    end
  endtask

  int snap;
  logic seen;

  initial begin
    rst = 1'b1; enable = 1'b0; invalidateTlb = 1'b0;
    command = MEM_LOAD; loadStoreUnitCommand = '{SIZE_W, 1'b0, 1'b0};
    imm = '0; srcIntRegValue1 = '0; srcIntRegValue2 = '0; srcFpRegValue2 = '0;
    tlb_off = 32'h7000; tlb_fault_cfg = 1'b0; rd_same = 1'b0; mem_stall = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[32'h8004 >> 2] = 32'h8000_0001;
    mem[32'h8000 >> 2] = 32'hAB00_0000;
    mem[32'h3000 >> 2] = 32'h1111_1111;
    mem[32'h3004 >> 2] = 32'h2222_2222;

    repeat (3) @(negedge clk);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset memReq", {63'd0, memReq}, 64'd0);
    check("reset tlbReq", {63'd0, tlbReq}, 64'd0);
    check("reset tlbFlush", {63'd0, tlbFlush}, 64'd0);
    check("reset resultValue", resultValue, 64'd0);
    check("reset resultAddr", {32'd0, resultAddr}, 64'd0);
    rst = 1'b0;

    do_op("LW", MEM_LOAD, SIZE_W, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd4, 32'd0, 64'd0,
          64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0, 4);
    do_op("LBU", MEM_LOAD, SIZE_B, 1'b1, 1'b0, 1'b0, 32'h1000, 32'd3, 32'd0, 64'd0,
          64'h0000_0000_0000_00AB, 1'b0, 1'b0, 4);
    do_op("LB", MEM_LOAD, SIZE_B, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd3, 32'd0, 64'd0,
          64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1'b0, 4);

    // VA wraps modulo 2^32 to 0x2002; identity translation from here.
    tlb_off = 32'h0;
    do_op("SH", MEM_STORE, SIZE_H, 1'b0, 1'b0, 1'b0, 32'hFFFF_F000, 32'h3002,
          32'h1234, 64'd0, 64'd0, 1'b0, 1'b0, 3);
    check_write("SH", 32'h2000, 4'b1100, 32'h1234_0000);
    do_op("SB", MEM_STORE, SIZE_B, 1'b0, 1'b0, 1'b0, 32'h2000, 32'd1,
          32'h1234_56AB, 64'd0, 64'd0, 1'b0, 1'b0, 3);
    check_write("SB", 32'h2000, 4'b0010, 32'h3456_AB00);

    do_op("FLD", MEM_LOAD, SIZE_D, 1'b0, 1'b1, 1'b0, 32'h3000, 32'd0, 32'd0, 64'd0,
          64'h2222_2222_1111_1111, 1'b0, 1'b0, 6);
    rd_same = 1'b1;
    do_op("FLW same-cycle", MEM_LOAD, SIZE_W, 1'b0, 1'b1, 1'b0, 32'h3000, 32'd4, 32'd0,
          64'd0, 64'hFFFF_FFFF_2222_2222, 1'b0, 1'b0, 3);
    rd_same = 1'b0;

    do_op("FSD", MEM_STORE, SIZE_D, 1'b0, 1'b1, 1'b0, 32'h3000, 32'd8, 32'd0,
          64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 1'b0, 1'b0, 4);
    check_write("FSD beat0", 32'h3008, 4'b1111, 32'hCCCC_DDDD);
    check_write("FSD beat1", 32'h300C, 4'b1111, 32'hAAAA_BBBB);

    tlb_fault_cfg = 1'b1;
    snap = memreq_cycles;
    do_op("SW fault", MEM_STORE, SIZE_W, 1'b0, 1'b0, 1'b0, 32'h5000, 32'd8,
          32'hDEAD_BEEF, 64'd0, 64'd0, 1'b0, 1'b1, 2);
    do_op("LW fault", MEM_LOAD, SIZE_W, 1'b0, 1'b0, 1'b0, 32'h6000, 32'd4,
          32'd0, 64'd0, 64'd0, 1'b1, 1'b0, 2);
    check("fault memReq cycles", 64'(memreq_cycles - snap), 64'd0);
    check("fault no writes", 64'(wq.size()), 64'd0);
    tlb_fault_cfg = 1'b0;

    snap = flush_cycles;
    do_op("flush", MEM_LOAD, SIZE_W, 1'b0, 1'b0, 1'b1, 32'h7000, 32'd0, 32'd0, 64'd0,
          64'd0, 1'b0, 1'b0, 4);
    check("flush held cycles", 64'(flush_cycles - snap), 64'd3);

    do_op("fence", MEM_FENCE, SIZE_W, 1'b0, 1'b0, 1'b0, 32'h4000, 32'h10, 32'd0, 64'd0,
          64'd0, 1'b0, 1'b0, 1);

    // Stall the bus, then reset while the request is outstanding.
    mem_stall = 1'b1;
    @(negedge clk);
    command = MEM_LOAD; loadStoreUnitCommand = '{SIZE_W, 1'b0, 1'b0};
    srcIntRegValue1 = 32'h1000; imm = 32'd4; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (memReq) seen = 1'b1;
    end
    check("midop memReq reached", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midop reset memReq", {63'd0, memReq}, 64'd0);
    check("midop reset tlbReq", {63'd0, tlbReq}, 64'd0);
    check("midop reset done", {63'd0, done}, 64'd0);
    check("midop reset resultAddr", {32'd0, resultAddr}, 64'd0);
    rst = 1'b0; enable = 1'b0; mem_stall = 1'b0;
    @(negedge clk);

    tlb_off = 32'h7000;
    do_op("LH after reset", MEM_LOAD, SIZE_H, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd6, 32'd0,
          64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
